router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
Input-side controller for the 1x3 router. It accepts a byte-serial packet stream, decodes the 2-bit destination address and sequences writes into one of three 16x9 output FIFOs, including the lfd_state header marker. It applies backpressure to the source via busy, checks the trailing parity byte, and generates per-FIFO soft resets when a downstream reader stalls.

Parameters:
TIMEOUT, 30, consecutive idle-read cycles before soft_rst fires
TCNT_W, 5, width of each timeout counter; must satisfy 2^TCNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
pkt_valid  in  1  source byte valid; low while the parity byte is presented
data_in  in  8  packet byte; header = [7:2] length (payload bytes), [1:0] address
fifo_full  in  3  full flags of FIFO0..2
fifo_empty  in  3  empty flags of FIFO0..2
read_enb  in  3  downstream read enables of FIFO0..2
busy  out  1  source must hold data_in/pkt_valid stable while high
we  out  3  one-hot FIFO write enable (combinational)
data_out  out  8  FIFO write data (combinational)
lfd_state  out  1  high exactly one cycle before the header write cycle
valid_out  out  3  ~fifo_empty
soft_rst  out  3  registered one-cycle soft reset per FIFO
parity_err  out  1  registered; parity mismatch of the last packet
len_err  out  1  registered; see Optional Feature

Behaviour:
- Reset (rst=0): FSM=DECODE_ADDRESS; addr_q, hdr_q, parity_acc, timeout counters = 0; soft_rst=0, parity_err=0, len_err=0. we=0 and lfd_state=0 follow from the state.
- A byte is accepted on any cycle with pkt_valid=1 (or the parity byte with pkt_valid=0 in LOAD_DATA) while busy=0.
- DECODE_ADDRESS (busy=0):
  - pkt_valid & data_in[1:0]==3 -> DROP_PACKET.
  - pkt_valid & valid addr: latch hdr_q=data_in, addr_q=data_in[1:0], parity_acc=data_in; clear parity_err and len_err. Go to LFD_SETUP if fifo_empty[addr], else WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY (busy=1): -> LFD_SETUP when fifo_empty[addr_q]=1.
- LFD_SETUP (busy=1, lfd_state=1, no write): -> LOAD_FIRST_DATA.
- LOAD_FIRST_DATA (busy=1): we[addr_q]=1, data_out=hdr_q -> LOAD_DATA.
- LOAD_DATA (busy = fifo_full[addr_q]):
  - fifo_full[addr_q]: no write -> FIFO_FULL_STATE. Full takes priority over all else.
  - else pkt_valid: we[addr_q]=1, data_out=data_in, parity_acc^=data_in.
  - else: parity byte. we[addr_q]=1, data_out=data_in, latch parity_rx=data_in -> CHECK_PARITY_ERROR.
- FIFO_FULL_STATE (busy=1, no write): -> LOAD_DATA when fifo_full[addr_q]=0. The held byte is written there; no byte is lost or duplicated.
- CHECK_PARITY_ERROR (busy=1): parity_err <= (parity_acc != parity_rx) -> DECODE_ADDRESS. parity_err holds until the next header is accepted.
- DROP_PACKET (busy=0, no writes): consume bytes; on pkt_valid=0 -> DECODE_ADDRESS.
- Soft reset, per FIFO i:
  - tcnt[i] increments while fifo_empty[i]=0 & read_enb[i]=0; it clears otherwise.
  - When tcnt[i] reaches TIMEOUT, soft_rst[i]=1 for the next cycle only and tcnt[i] clears.
- soft_rst[addr_q] while in WAIT_TILL_EMPTY/LFD_SETUP/LOAD_FIRST_DATA/LOAD_DATA/FIFO_FULL_STATE:
  - Next state is DROP_PACKET, or DECODE_ADDRESS if the parity byte is being accepted that cycle.
  - Takes priority over all other transitions. parity_err is not updated.
- Length 0 header: LOAD_DATA receives only the parity byte; this is legal.
- Reset mid-packet returns to DECODE_ADDRESS immediately; no write occurs in the reset cycle.

Optional Feature:
ROUTER_LEN_CHECK_EN:
- Defined: a 6-bit payload counter clears on header accept and increments on each LOAD_DATA write with pkt_valid=1. In CHECK_PARITY_ERROR, len_err <= (count != hdr_q[7:2]), with the same hold/clear rules as parity_err.
- Undefined: no counter is built and len_err is tied to 0.

Test Plan:
- Header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D, fifo_empty=111 -> lfd_state 1 cycle, then we=010 for 5 consecutive cycles carrying 0x0D,0x11,0x22,0x33,0x0D; parity_err=0; busy high for 3 cycles after the header.
- Same packet with parity 0x0C -> identical writes; parity_err=1 two cycles after the parity byte, cleared on the next header.
- fifo_full[1]=1 for 4 cycles while 0x22 is presented -> busy=1, we=000 for those 4 cycles (plus the FIFO_FULL exit cycle), then 0x22 written exactly once.
- Header 0x0E (addr 2) with fifo_empty[2]=0 for 10 cycles -> busy=1, we=000 throughout; LFD_SETUP follows the cycle fifo_empty[2] rises.
- fifo_empty[0]=0, read_enb[0]=0 held -> soft_rst[0] single pulse after 30 idle cycles. Repeat with read_enb[0]=1 at idle cycle 29 -> no pulse.
- Header 0x07 (addr 3) followed by 2 bytes, then pkt_valid=0 -> we=000 throughout, busy=0; the next header 0x04 (addr 0) is routed normally.

Source files
------------

// File: rtl/router_ctrl.sv
// Input-side controller of the 1x3 router: header decode, FIFO write sequencing, parity check, stall soft resets.
// Optional payload length check is built when ROUTER_LEN_CHECK_EN is defined; otherwise len_err is tied low.
module router_ctrl #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned TCNT_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic [2:0] we,
  output logic [7:0] data_out,
  output logic       lfd_state,
  output logic [2:0] valid_out,
  output logic [2:0] soft_rst,
  output logic       parity_err,
  output logic       len_err
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LFD_SETUP,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    CHECK_PARITY_ERROR,
    DROP_PACKET
  } state_t;

  state_t     state, state_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] parity_acc, parity_acc_d;
  logic [7:0] parity_rx, parity_rx_d;
  logic       parity_err_d;
  logic       wr;
  logic       parity_byte;

  // Address 3 is never latched; the padded bit keeps the selects in range.
  logic [3:0] full_ext, empty_ext, srst_ext;
  logic [2:0] addr_oh;
  logic       full_sel, empty_sel, srst_sel;

  assign full_ext  = {1'b0, fifo_full};
  assign empty_ext = {1'b0, fifo_empty};
  assign srst_ext  = {1'b0, soft_rst};
  assign full_sel  = full_ext[addr_q];
  assign empty_sel = empty_ext[addr_q];
  assign srst_sel  = srst_ext[addr_q];
  assign addr_oh   = 3'(4'b0001 << addr_q);
  assign valid_out = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= DECODE_ADDRESS;
      addr_q     <= '0;
      hdr_q      <= '0;
      parity_acc <= '0;
      parity_rx  <= '0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      hdr_q      <= hdr_d;
      parity_acc <= parity_acc_d;
      parity_rx  <= parity_rx_d;
      parity_err <= parity_err_d;
    end
  end

  // Next-state, datapath and combinational write-side outputs.
  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    hdr_d        = hdr_q;
    parity_acc_d = parity_acc;
    parity_rx_d  = parity_rx;
    parity_err_d = parity_err;
    busy         = 1'b0;
    lfd_state    = 1'b0;
    data_out     = data_in;
    wr           = 1'b0;
    parity_byte  = 1'b0;

    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (data_in[1:0] == 2'd3) begin
            state_d = DROP_PACKET;
          end else begin
            hdr_d        = data_in;
            addr_d       = data_in[1:0];
            parity_acc_d = data_in;
            parity_err_d = 1'b0;
            state_d      = empty_ext[data_in[1:0]] ? LFD_SETUP : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty_sel) state_d = LFD_SETUP;
      end
      LFD_SETUP: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        state_d   = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy     = 1'b1;
        wr       = 1'b1;
        data_out = hdr_q;
        state_d  = LOAD_DATA;
      end
      LOAD_DATA: begin
        busy = full_sel;
        if (full_sel) begin
          state_d = FIFO_FULL_STATE;
        end else if (pkt_valid) begin
          wr           = 1'b1;
          parity_acc_d = parity_acc ^ data_in;
        end else begin
          wr          = 1'b1;
          parity_byte = 1'b1;
          parity_rx_d = data_in;
          state_d     = CHECK_PARITY_ERROR;
        end
      end
      FIFO_FULL_STATE: begin
        busy = 1'b1;
        if (!full_sel) state_d = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: begin
        busy         = 1'b1;
        parity_err_d = (parity_acc != parity_rx);
        state_d      = DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A soft reset of the target FIFO abandons the packet in flight.
    if (srst_sel && (state inside {WAIT_TILL_EMPTY, LFD_SETUP, LOAD_FIRST_DATA,
                                   LOAD_DATA, FIFO_FULL_STATE})) begin
      state_d = parity_byte ? DECODE_ADDRESS : DROP_PACKET;
    end

    // No write may leak out during the reset cycle.
    we = (wr && rst) ? addr_oh : 3'b000;
  end

  // Per-FIFO stall timers: a full TIMEOUT run of unread, non-empty cycles fires one soft_rst pulse.
  logic [TCNT_W-1:0] tcnt [3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      soft_rst <= '0;
      for (int i = 0; i < 3; i++) tcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        soft_rst[i] <= 1'b0;
        if (!fifo_empty[i] && !read_enb[i]) begin
          if (tcnt[i] == TCNT_W'(TIMEOUT - 1)) begin
            tcnt[i]     <= '0;
            soft_rst[i] <= 1'b1;
          end else begin
            tcnt[i] <= tcnt[i] + TCNT_W'(1);
          end
        end else begin
          tcnt[i] <= '0;
        end
      end
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  logic [5:0] pay_cnt, pay_cnt_d;
  logic       len_err_d;

  // Payload byte count compared against the header length when the parity byte lands.
  always_comb begin
    pay_cnt_d = pay_cnt;
    len_err_d = len_err;
    if (state == DECODE_ADDRESS && pkt_valid && data_in[1:0] != 2'd3) begin
      pay_cnt_d = '0;
      len_err_d = 1'b0;
    end else if (state == LOAD_DATA && !full_sel && pkt_valid) begin
      pay_cnt_d = pay_cnt + 6'd1;
    end else if (state == CHECK_PARITY_ERROR) begin
      len_err_d = (pay_cnt != hdr_q[7:2]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      pay_cnt <= pay_cnt_d;
      len_err <= len_err_d;
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: routing, backpressure, parity, drop, mid-packet reset and stall timeouts.
module tb_router_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] we;
  logic [7:0] data_out;
  logic       lfd_state;
  logic [2:0] valid_out;
  logic [2:0] soft_rst;
  logic       parity_err;
  logic       len_err;

  int errors = 0;
  int checks = 0;

  router_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .busy       (busy),
    .we         (we),
    .data_out   (data_out),
    .lfd_state  (lfd_state),
    .valid_out  (valid_out),
    .soft_rst   (soft_rst),
    .parity_err (parity_err),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: new inputs settle 2ns after the edge, outputs are sampled 1ns later.
  task automatic cyc(input logic pv, input logic [7:0] d, input logic [2:0] full,
                     input logic [2:0] empty, input logic [2:0] e_we, input logic [7:0] e_do,
                     input logic e_busy, input logic e_lfd, input string tag);
    @(posedge clk);
    #2;
    pkt_valid  = pv;
    data_in    = d;
    fifo_full  = full;
    fifo_empty = empty;
    #1;
    chk({tag, "/we"}, 8'(we), 8'(e_we));
    chk({tag, "/busy"}, 8'(busy), 8'(e_busy));
    chk({tag, "/lfd"}, 8'(lfd_state), 8'(e_lfd));
    if (e_we != 3'b000) chk({tag, "/data"}, data_out, e_do);
  endtask

  initial begin
    rst        = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    read_enb   = 3'b000;
    repeat (2) @(posedge clk);
    #3;
    chk("rst/busy", 8'(busy), 8'h00);
    chk("rst/we", 8'(we), 8'h00);
    chk("rst/lfd", 8'(lfd_state), 8'h00);
    chk("rst/soft_rst", 8'(soft_rst), 8'h00);
    chk("rst/parity_err", 8'(parity_err), 8'h00);
    chk("rst/len_err", 8'(len_err), 8'h00);
    chk("rst/valid_out", 8'(valid_out), 8'h00);
    rst = 1'b1;

    // Good packet to FIFO1: header 0D, payload 11 22 33, parity 0D.
    cyc(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p1_hdr");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "p1_lfd");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b1, 1'b0, "p1_first");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h11, 1'b0, 1'b0, "p1_d11");
    cyc(1'b1, 8'h22, 3'b000, 3'b111, 3'b010, 8'h22, 1'b0, 1'b0, "p1_d22");
    cyc(1'b1, 8'h33, 3'b000, 3'b111, 3'b010, 8'h33, 1'b0, 1'b0, "p1_d33");
    cyc(1'b0, 8'h0D, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b0, 1'b0, "p1_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p1_chk");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p1_idle");
    chk("p1/parity_err", 8'(parity_err), 8'h00);

    // Same packet with a wrong parity byte 0C.
    cyc(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p2_hdr");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "p2_lfd");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b1, 1'b0, "p2_first");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h11, 1'b0, 1'b0, "p2_d11");
    cyc(1'b1, 8'h22, 3'b000, 3'b111, 3'b010, 8'h22, 1'b0, 1'b0, "p2_d22");
    cyc(1'b1, 8'h33, 3'b000, 3'b111, 3'b010, 8'h33, 1'b0, 1'b0, "p2_d33");
    cyc(1'b0, 8'h0C, 3'b000, 3'b111, 3'b010, 8'h0C, 1'b0, 1'b0, "p2_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p2_chk");
    chk("p2_chk/parity_err", 8'(parity_err), 8'h00);
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p2_idle");
    chk("p2/parity_err", 8'(parity_err), 8'h01);

    // FIFO1 full for 4 cycles while 22 is held; header clears the old parity error.
    cyc(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p3_hdr");
    chk("p3_hdr/parity_err_hold", 8'(parity_err), 8'h01);
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "p3_lfd");
    chk("p3_lfd/parity_err_clr", 8'(parity_err), 8'h00);
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b1, 1'b0, "p3_first");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h11, 1'b0, 1'b0, "p3_d11");
    for (int n = 0; n < 4; n++)
      cyc(1'b1, 8'h22, 3'b010, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p3_full");
    cyc(1'b1, 8'h22, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p3_full_exit");
    cyc(1'b1, 8'h22, 3'b000, 3'b111, 3'b010, 8'h22, 1'b0, 1'b0, "p3_d22");
    cyc(1'b1, 8'h33, 3'b000, 3'b111, 3'b010, 8'h33, 1'b0, 1'b0, "p3_d33");
    cyc(1'b0, 8'h0D, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b0, 1'b0, "p3_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p3_chk");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p3_idle");
    chk("p3/parity_err", 8'(parity_err), 8'h00);

    // FIFO2 not empty at header time: wait, then route A0 B1 C2 with parity DD.
    cyc(1'b1, 8'h0E, 3'b000, 3'b011, 3'b000, 8'h00, 1'b0, 1'b0, "p4_hdr");
    for (int n = 0; n < 9; n++)
      cyc(1'b1, 8'hA0, 3'b000, 3'b011, 3'b000, 8'h00, 1'b1, 1'b0, "p4_wait");
    chk("p4_wait/valid_out", 8'(valid_out), 8'h04);
    cyc(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p4_rise");
    cyc(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "p4_lfd");
    cyc(1'b1, 8'hA0, 3'b000, 3'b111, 3'b100, 8'h0E, 1'b1, 1'b0, "p4_first");
    cyc(1'b1, 8'hA0, 3'b000, 3'b111, 3'b100, 8'hA0, 1'b0, 1'b0, "p4_dA0");
    cyc(1'b1, 8'hB1, 3'b000, 3'b111, 3'b100, 8'hB1, 1'b0, 1'b0, "p4_dB1");
    cyc(1'b1, 8'hC2, 3'b000, 3'b111, 3'b100, 8'hC2, 1'b0, 1'b0, "p4_dC2");
    cyc(1'b0, 8'hDD, 3'b000, 3'b111, 3'b100, 8'hDD, 1'b0, 1'b0, "p4_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "p4_chk");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "p4_idle");
    chk("p4/parity_err", 8'(parity_err), 8'h00);

    // Zero-length packet: header 01 then parity 01 only.
    cyc(1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "l0_hdr");
    cyc(1'b0, 8'h01, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "l0_lfd");
    cyc(1'b0, 8'h01, 3'b000, 3'b111, 3'b010, 8'h01, 1'b1, 1'b0, "l0_first");
    cyc(1'b0, 8'h01, 3'b000, 3'b111, 3'b010, 8'h01, 1'b0, 1'b0, "l0_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "l0_chk");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "l0_idle");
    chk("l0/parity_err", 8'(parity_err), 8'h00);

    // Address 3 is dropped; the following header 04 to FIFO0 is routed normally.
    cyc(1'b1, 8'h07, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "drop_hdr");
    cyc(1'b1, 8'h55, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "drop_b0");
    cyc(1'b1, 8'h66, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "drop_b1");
    cyc(1'b0, 8'h99, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "drop_end");
    cyc(1'b1, 8'h04, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "a0_hdr");
    cyc(1'b1, 8'h5A, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "a0_lfd");
    cyc(1'b1, 8'h5A, 3'b000, 3'b111, 3'b001, 8'h04, 1'b1, 1'b0, "a0_first");
    cyc(1'b1, 8'h5A, 3'b000, 3'b111, 3'b001, 8'h5A, 1'b0, 1'b0, "a0_d5A");
    cyc(1'b0, 8'h5E, 3'b000, 3'b111, 3'b001, 8'h5E, 1'b0, 1'b0, "a0_par");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b0, "a0_chk");
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "a0_idle");
    chk("a0/parity_err", 8'(parity_err), 8'h00);

    // Reset asserted during the first payload cycle: no write, back to address decode.
    cyc(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "mr_hdr");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 8'h00, 1'b1, 1'b1, "mr_lfd");
    cyc(1'b1, 8'h11, 3'b000, 3'b111, 3'b010, 8'h0D, 1'b1, 1'b0, "mr_first");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rst/we", 8'(we), 8'h00);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    pkt_valid = 1'b0;
    #1;
    chk("mr_after/busy", 8'(busy), 8'h00);
    chk("mr_after/we", 8'(we), 8'h00);
    chk("mr_after/lfd", 8'(lfd_state), 8'h00);
    cyc(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 1'b0, 1'b0, "mr_idle");

    // FIFO0 holds data and is never read: single soft_rst pulse after 30 idle cycles.
    fifo_empty = 3'b110;
    for (int n = 1; n <= 31; n++) begin
      @(posedge clk);
      #3;
      chk($sformatf("to_idle%0d/soft_rst", n), 8'(soft_rst), (n == 30) ? 8'h01 : 8'h00);
    end
    chk("to/valid_out", 8'(valid_out), 8'h01);

    // A read at idle cycle 29 restarts the timer: no pulse.
    fifo_empty = 3'b111;
    @(posedge clk);
    #3;
    fifo_empty = 3'b110;
    for (int n = 1; n <= 40; n++) begin
      read_enb = (n == 29) ? 3'b001 : 3'b000;
      @(posedge clk);
      #3;
      chk($sformatf("rd_idle%0d/soft_rst", n), 8'(soft_rst), 8'h00);
    end
    read_enb   = 3'b000;
    fifo_empty = 3'b111;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
